// File: rtl/des_pkg.sv
// Shared DES constants: widths, engine state encoding, permutation and S-box tables.
// Tables hold the standard 1-based DES bit numbers; helpers map them onto [0:N-1] vectors.
package des_pkg;

    localparam int unsigned BLOCK_W  = 64;
    localparam int unsigned HALF_W   = 32;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUNDS   = 16;
    localparam int unsigned N_SBOX   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL
    } state_t;

    localparam int unsigned IP_TBL [0:63] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_TBL [0:63] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned E_TBL [0:47] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TBL [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is four 16-entry rows laid end to end: entry = row*16 + column.
    localparam int unsigned SBOX [0:7][0:63] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [0:63] ip_perm(input logic [0:63] d);
        logic [0:63] o;
        for (int unsigned i = 0; i < 64; i++) o[6'(i)] = d[6'(IP_TBL[6'(i)] - 1)];
        return o;
    endfunction

    function automatic logic [0:63] fp_perm(input logic [0:63] d);
        logic [0:63] o;
        for (int unsigned i = 0; i < 64; i++) o[6'(i)] = d[6'(FP_TBL[6'(i)] - 1)];
        return o;
    endfunction

    function automatic logic [0:47] e_expand(input logic [0:31] d);
        logic [0:47] o;
        for (int unsigned i = 0; i < 48; i++) o[6'(i)] = d[5'(E_TBL[6'(i)] - 1)];
        return o;
    endfunction

    function automatic logic [0:31] p_perm(input logic [0:31] d);
        logic [0:31] o;
        for (int unsigned i = 0; i < 32; i++) o[5'(i)] = d[5'(P_TBL[5'(i)] - 1)];
        return o;
    endfunction

    // Outer bits {g[0], g[5]} pick the row, inner g[1:4] the column.
    function automatic logic [0:3] sbox_lookup(input int unsigned box, input logic [0:5] g);
        logic [31:0] v;
        v = SBOX[3'(box)][{g[0], g[5], g[1:4]}];
        return v[3:0];
    endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Handshake and data bus between the requester/key schedule side and the DES round engine.
interface des_round_engine_if;
    import des_pkg::*;

    logic                  start;
    logic [0:BLOCK_W-1]    data_in;
    logic [0:SUBKEY_W-1]   subkey;
    logic                  subkey_valid;
    logic                  key_start;
    logic                  busy;
    logic                  done;
    logic [0:BLOCK_W-1]    data_out;

    modport master (
        output start, data_in, subkey, subkey_valid,
        input  key_start, busy, done, data_out
    );

    modport slave (
        input  start, data_in, subkey, subkey_valid,
        output key_start, busy, done, data_out
    );

endinterface

// File: rtl/des_f_function.sv
// DES round function f(R, K): expand, key mix, eight S-boxes, P permutation. Purely combinational.
module des_f_function
    import des_pkg::*;
(
    input  logic [0:HALF_W-1]   r,
    input  logic [0:SUBKEY_W-1] k,
    output logic [0:HALF_W-1]   f
);

    logic [0:SUBKEY_W-1] x;
    logic [0:HALF_W-1]   s;

    assign x = e_expand(r) ^ k;

    for (genvar g = 0; g < N_SBOX; g++) begin : g_sbox
        assign s[g*4 +: 4] = sbox_lookup(g, x[g*6 +: 6]);
    end

    assign f = p_perm(s);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES datapath: IP, sixteen Feistel rounds paced by subkey_valid, then FP with a done pulse.
module des_round_engine
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    des_round_engine_if.slave bus
);

    state_t             state;
    logic [0:HALF_W-1]  l_q;
    logic [0:HALF_W-1]  r_q;
    logic [0:HALF_W-1]  f_out;
    logic [3:0]         cnt_q;
    logic [0:BLOCK_W-1] ip_out;

    assign ip_out        = ip_perm(bus.data_in);
    assign bus.key_start = (state == ST_IDLE) && bus.start;

    des_f_function u_f (
        .r (r_q),
        .k (bus.subkey),
        .f (f_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            l_q          <= '0;
            r_q          <= '0;
            cnt_q        <= '0;
            bus.data_out <= '0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        l_q      <= ip_out[0:HALF_W-1];
                        r_q      <= ip_out[HALF_W:BLOCK_W-1];
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (bus.subkey_valid) begin
                        l_q <= r_q;
                        r_q <= l_q ^ f_out;
                        // Counter parks at the last round so it never wraps within a block.
                        if (cnt_q == 4'(ROUNDS - 1)) begin
                            state <= ST_FINAL;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ST_FINAL: begin
                    bus.data_out <= fp_perm({r_q, l_q});
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: known-answer blocks, stalls, ignored starts, mid-block reset
// and random keys/plaintexts checked against a loop-based DES reference with its own key schedule.
module tb_des_round_engine;
    import des_pkg::*;

    localparam int unsigned PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int unsigned SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;

    logic clk;
    logic rst;
    des_round_engine_if bus ();

    des_round_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    logic [47:0] cur_ks [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Standard DES key schedule; rev delivers K16..K1 for decryption.
    task automatic make_keys(input logic [63:0] key, input bit rev);
        logic [55:0] pc1;
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        for (int n = 1; n <= 56; n++) pc1[56-n] = key[64-PC1_TBL[n-1]];
        c = pc1[55:28];
        d = pc1[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < int'(SHIFTS[i]); s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int n = 1; n <= 48; n++) k[48-n] = cd[56-PC2_TBL[n-1]];
            cur_ks[rev ? 15 - i : i] = k;
        end
    endtask

    // Reference DES on a [63:0] word where DES bit n sits at position 64-n.
    function automatic logic [63:0] des_model(input logic [63:0] blk);
        logic [63:0] t, o;
        logic [31:0] l, r, f, s, tmp;
        logic [47:0] x;
        logic [5:0]  six;
        int unsigned idx;
        int unsigned v;
        for (int n = 1; n <= 64; n++) t[64-n] = blk[64-IP_TBL[n-1]];
        l = t[63:32];
        r = t[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int n = 1; n <= 48; n++) x[48-n] = r[32-E_TBL[n-1]];
            x = x ^ cur_ks[rnd];
            for (int b = 0; b < 8; b++) begin
                six = x[47-6*b -: 6];
                idx = (six[5] ? 32 : 0) + (six[0] ? 16 : 0) + int'(six[4:1]);
                v = SBOX[b][idx];
                s[31-4*b -: 4] = v[3:0];
            end
            for (int n = 1; n <= 32; n++) f[32-n] = s[32-P_TBL[n-1]];
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        t = {r, l};
        for (int n = 1; n <= 64; n++) o[64-n] = t[64-FP_TBL[n-1]];
        return o;
    endfunction

    // Starts a block in the current (idle) cycle and returns in the cycle done is high.
    // Stalls are inserted before randomly chosen rounds 1..15; poke keeps start high with junk data.
    task automatic run_block(input string tag, input logic [63:0] pt, input logic [63:0] exp,
                             input int unsigned n_stalls, input bit poke);
        int unsigned stall_at [16];
        foreach (stall_at[i]) stall_at[i] = 0;
        for (int unsigned j = 0; j < n_stalls; j++) stall_at[$urandom_range(15, 1)]++;
        bus.data_in      = pt;
        bus.start        = 1'b1;
        bus.subkey_valid = 1'(($urandom_range(1, 0)));
        bus.subkey       = 48'(rnd64());
        #1 chk({tag, "_key_start"}, 64'(bus.key_start), 64'd1);
        tick();
        chk({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
        bus.start = poke;
        for (int k = 0; k < 16; k++) begin
            for (int unsigned s = 0; s < stall_at[k]; s++) begin
                bus.subkey_valid = 1'b0;
                bus.subkey       = 48'(rnd64());
                if (poke) bus.data_in = rnd64();
                #1 chk({tag, "_key_start_stall"}, 64'(bus.key_start), 64'd0);
                tick();
                chk({tag, "_busy_stall"}, 64'(bus.busy), 64'd1);
                chk({tag, "_done_stall"}, 64'(bus.done), 64'd0);
            end
            bus.subkey_valid = 1'b1;
            bus.subkey       = cur_ks[k];
            if (poke) bus.data_in = rnd64();
            #1 chk({tag, "_key_start_round"}, 64'(bus.key_start), 64'd0);
            tick();
            chk({tag, "_busy_round"}, 64'(bus.busy), 64'd1);
            chk({tag, "_done_early"}, 64'(bus.done), 64'd0);
        end
        bus.subkey_valid = 1'(($urandom_range(1, 0)));
        bus.subkey       = 48'(rnd64());
        #1 chk({tag, "_key_start_final"}, 64'(bus.key_start), 64'd0);
        tick();
        bus.start        = 1'b0;
        bus.subkey_valid = 1'b0;
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_data_out"}, bus.data_out, exp);
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic abort_mid_block();
        make_keys(KAT_KEY, 1'b0);
        bus.data_in = KAT_PT;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.subkey_valid = 1'b1;
            bus.subkey       = cur_ks[k];
            tick();
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_data_out", bus.data_out, 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        tick();
        rst = 1'b1;
        bus.subkey_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_no_done", 64'(bus.done), 64'd0);
            chk("abort_idle_busy", 64'(bus.busy), 64'd0);
        end
        bus.subkey_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] key, pt;
        n_vec = 0;
        n_err = 0;
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.data_in      = '0;
        bus.subkey       = '0;
        bus.subkey_valid = 1'b0;
        tick();
        tick();
        chk("rst_data_out", bus.data_out, 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_key_start", 64'(bus.key_start), 64'd0);
        rst = 1'b1;
        bus.subkey_valid = 1'b1;
        tick();
        chk("idle_valid_ignored", 64'(bus.busy), 64'd0);
        bus.subkey_valid = 1'b0;

        make_keys(KAT_KEY, 1'b0);
        run_block("kat", KAT_PT, KAT_CT, 0, 1'b0);
        tick();
        chk("done_single", 64'(bus.done), 64'd0);
        chk("data_out_hold", bus.data_out, KAT_CT);

        run_block("stall", KAT_PT, KAT_CT, 3, 1'b0);
        tick();
        run_block("busy_start", KAT_PT, KAT_CT, 0, 1'b1);
        tick();
        chk("busy_start_one_done", 64'(bus.done), 64'd0);

        abort_mid_block();
        make_keys(KAT_KEY, 1'b0);
        run_block("after_abort", KAT_PT, KAT_CT, 0, 1'b0);
        make_keys(64'd0, 1'b0);
        run_block("back_to_back", 64'd0, ZERO_CT, 0, 1'b0);
        make_keys(KAT_KEY, 1'b1);
        run_block("decrypt", KAT_CT, KAT_PT, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            key = rnd64();
            pt  = rnd64();
            make_keys(key, 1'(($urandom_range(1, 0))));
            run_block("random", pt, des_model(pt), $urandom_range(4, 0), 1'(($urandom_range(1, 0))));
        end
        tick();
        chk("final_done_low", 64'(bus.done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_round_engine.md
# des_round_engine

Iterative DES encryption datapath: the stage directly downstream of the key schedule block, consuming one 48-bit subkey per round. It accepts a 64-bit plaintext block and requests the subkey stream from the key schedule. It applies IP, 16 Feistel rounds (one per clock when a subkey is available) and FP, then presents the 64-bit ciphertext with a one-cycle done pulse.

## Interface
- No parameters; DES widths are fixed constants in the shared package.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to encrypt `data_in`; sampled only in IDLE.
- `data_in`  in  [0:63]  plaintext; bit 0 = DES bit 1 (MSB).
- `subkey`  in  [0:48-1]  round subkey from the key schedule, K1..K16 in order.
- `subkey_valid`  in  1  `subkey` holds the next subkey this cycle (key schedule's ready).
- `key_start`  out  1  one-cycle pulse telling the key schedule to begin producing K1..K16.
- `busy`  out  1  high in ROUND and FINAL.
- `done`  out  1  one-cycle pulse; `data_out` is newly valid.
- `data_out`  out  [0:63]  ciphertext; holds until the next done.

## Operation
- State machine: IDLE, ROUND, FINAL.
- IDLE:
  - On `start`=1: L,R <= IP(`data_in`) halves; round counter <= 0; `key_start`=1 that cycle; go to ROUND.
  - `subkey_valid` is ignored.
- ROUND:
  - Each cycle with `subkey_valid`=1: L <= R; R <= L ^ f(R, `subkey`); counter++.
  - Cycles with `subkey_valid`=0 stall: L, R and the counter hold.
  - When counter = 15 and `subkey_valid`=1, go to FINAL.
- FINAL:
  - `data_out` <= FP({R16, L16}), i.e. the final swap is applied.
  - `done` <= 1 for one cycle; go to IDLE.
- f(R,K):
  - E expansion of R to 48 bits, XOR with K.
  - Eight 6-to-4 S-boxes: row = bits 0 and 5 of each group, column = bits 1–4.
  - P permutation to 32 bits.
- `start` while busy is ignored; no queuing.
- Counter is 4 bits. It never wraps inside a block and is reloaded to 0 on every accepted start.
- Encryption only: decryption is obtained by the key schedule supplying K16..K1. The engine is direction-agnostic.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; L, R, counter = 0; `data_out` = 0; `done`, `busy`, `key_start` = 0.
- Reset mid-operation aborts the block: no done, and `data_out` is cleared.
- `key_start` is combinational from IDLE && `start` (same cycle as acceptance).
- `busy` is registered: high from the edge after acceptance until the edge that returns to IDLE.
- Latency with `subkey_valid` continuously high:
  - Edge 0 accepts `start`.
  - Edges 1–16 perform rounds.
  - Edge 17 registers `data_out` and raises `done`.
  - So `done` is high in the cycle after edge 17; each stall cycle adds one.
- `start` may be accepted in the cycle `done` is high, since state is IDLE then. Back-to-back throughput is one block per 18 cycles.
- `subkey_valid` in FINAL is ignored.
- `subkey` is sampled only on edges where ROUND && `subkey_valid`.

## Structure
- Package `des_pkg`:
  - Width constants: block 64, half 32, subkey 48, rounds 16.
  - State enum.
  - IP, FP, E and P permutation tables as constant index arrays.
  - Eight S-box constant tables (4x16 each).
- Sub-module `des_f_function`: purely combinational, R[0:31] and K[0:47] in, f[0:31] out.
- The engine holds the FSM, L/R registers, counter and output register.

## Test plan
- Standard vector: feed K1..K16 for key 133457799BBCDFF1 (K1 = 1B02EFFC7072 … K16 = CB3D8B0E17F5) with `subkey_valid` held high; plaintext 0123456789ABCDEF -> `data_out` = 85E813540F0AB405, `done` exactly 17 edges after start acceptance, `key_start` a single pulse.
- Stalls: same vector with `subkey_valid` low for 3 random cycles between rounds -> same ciphertext, `done` delayed by exactly 3 cycles, L/R hold during stalls.
- Start ignored while busy: assert `start` with different `data_in` during ROUND -> no second `key_start`, result still 85E813540F0AB405, one `done` only.
- Reset mid-operation: deassert `rst` (drive low) at round 8 -> `data_out` = 0, `busy` = 0, no `done`; a fresh start then yields the correct ciphertext.
- Back-to-back: assert `start` in the `done` cycle with plaintext 0000000000000000 and key 0000000000000000 subkeys -> second `done` 17 edges later, `data_out` = 8CA64DE9C1B123A7.
- Decrypt via reversed subkeys: K16..K1 of key 133457799BBCDFF1, input 85E813540F0AB405 -> `data_out` = 0123456789ABCDEF.
